// File: rtl/lzc_pipe.sv
// lzc_pipe -- two-stage pipelined leading-zero counter with valid/ready handshake.
//
// Used in the FP add/sub normalisation path, between the mantissa adder and
// the exponent adjust/shift logic. The operand is cut into GROUP-bit slices.
// Stage 1 counts leading zeros in each slice and flags the slices that are
// nonzero. Stage 2 picks the first nonzero slice from the MSB end and merges
// its count with the slice offset.
//
// Parameters:
//   WIDTH  operand width, a multiple of GROUP, 8..64
//   GROUP  slice width, a power of two (>= 2)
//   CW     count width, derived as $clog2(WIDTH+1)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   operand valid
//   in_ready_o   block can accept an operand this cycle
//   a_i          operand; bit WIDTH-1 is the MSB
//   out_valid_o  result valid
//   out_ready_i  downstream accepts the result
//   cnt_o        number of leading zeros, 0..WIDTH
//   zero_o       operand was all zeros
//   norm_o       a_i << cnt_o, zero-filled (only with LZC_PIPE_NORM_EN)
//
// Build option:
//   LZC_PIPE_NORM_EN  when defined, adds norm_o and the barrel shifter. Stage 1
//                     then also keeps the raw operand. The count path is the
//                     same in both builds.

module lzc_pipe #(
  parameter  int WIDTH = 24,
  parameter  int GROUP = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    cnt_o,
  output logic             zero_o
`ifdef LZC_PIPE_NORM_EN
  ,
  output logic [WIDTH-1:0] norm_o
`endif
);

  localparam int NG = WIDTH / GROUP;
  localparam int GL = $clog2(GROUP);

  if ((WIDTH % GROUP) != 0 || GROUP < 2 || (GROUP & (GROUP - 1)) != 0) begin : g_param_chk
    $error("lzc_pipe: WIDTH must be a multiple of GROUP, GROUP a power of two >= 2");
  end

  // Leading zeros within one slice. The result for an all-zero slice is
  // don't-care, because the merge uses the nonzero flag to skip that slice.
  function automatic logic [GL-1:0] slice_lz(input logic [GROUP-1:0] s);
    logic [GL-1:0] n;
    n = '0;
    // Scan upward so that the highest set bit is the last one written.
    for (int i = 0; i < GROUP; i++) begin
      if (s[i]) n = GL'(GROUP - 1 - i);
    end
    return n;
  endfunction

  // Handshake and advance control.
  logic s1_valid;
  logic s2_valid;
  logic s1_load;
  logic s2_load;
  logic in_xfer;

  assign s2_load     = s1_valid && (!s2_valid || out_ready_i);
  assign s1_load     = !s1_valid || s2_load;
  assign in_ready_o  = !s1_valid || !s2_valid || out_ready_i;
  assign in_xfer     = in_valid_i && in_ready_o;
  assign out_valid_o = s2_valid;

  // Stage 1: per-slice counts and nonzero flags. Slice 0 is the MSB slice.
  logic [NG-1:0][GL-1:0] z_d;
  logic [NG-1:0]         v_d;
  logic [NG-1:0][GL-1:0] s1_z;
  logic [NG-1:0]         s1_v;

  always_comb begin
    z_d = '0;
    v_d = '0;
    for (int g = 0; g < NG; g++) begin
      z_d[g] = slice_lz(a_i[WIDTH-1-g*GROUP -: GROUP]);
      v_d[g] = |a_i[WIDTH-1-g*GROUP -: GROUP];
    end
  end

`ifdef LZC_PIPE_NORM_EN
  logic [WIDTH-1:0] s1_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_z     <= '0;
      s1_v     <= '0;
`ifdef LZC_PIPE_NORM_EN
      s1_a     <= '0;
`endif
    end else if (s1_load) begin
      s1_valid <= in_valid_i;
      // a_i is only sampled on a real transfer, so an X operand with
      // in_valid_i low never reaches the data registers.
      if (in_valid_i) begin
        s1_z <= z_d;
        s1_v <= v_d;
`ifdef LZC_PIPE_NORM_EN
        s1_a <= a_i;
`endif
      end
    end
  end

  // Stage 2: priority merge. Walk from the LSB slice upward so that the
  // first nonzero slice from the MSB end is the last one to write cnt_d.
  logic [CW-1:0] cnt_d;
  logic          zero_d;

  always_comb begin
    cnt_d  = CW'(WIDTH);
    zero_d = 1'b1;
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_v[g]) begin
        cnt_d  = CW'(g * GROUP) + CW'(s1_z[g]);
        zero_d = 1'b0;
      end
    end
  end

`ifdef LZC_PIPE_NORM_EN
  // Log-depth barrel: one conditional power-of-two shift per count bit.
  // An all-zero operand stays zero whatever the count is.
  logic [WIDTH-1:0] norm_d;

  always_comb begin
    norm_d = s1_a;
    for (int b = 0; b < CW; b++) begin
      if (cnt_d[b]) norm_d = norm_d << (1 << b);
    end
  end
`endif

  // The output registers change only when stage 2 loads. On a drain with
  // no new load, the data outputs keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      cnt_o    <= '0;
      zero_o   <= 1'b0;
`ifdef LZC_PIPE_NORM_EN
      norm_o   <= '0;
`endif
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      cnt_o    <= cnt_d;
      zero_o   <= zero_d;
`ifdef LZC_PIPE_NORM_EN
      norm_o   <= norm_d;
`endif
    end else if (out_ready_i) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lzc_pipe.sv
module tb_lzc_pipe;
  localparam int W  = 24;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [W-1:0]  a_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [CW-1:0] cnt_o;
  logic          zero_o;
`ifdef LZC_PIPE_NORM_EN
  logic [W-1:0]  norm_o;
`endif

  // Extra instances used for the parameter sweep.
  logic        v32 = 1'b0, ir32, ov32, z32;
  logic [31:0] a32 = '0;
  logic [5:0]  c32;
  logic        v16 = 1'b0, ir16, ov16, z16;
  logic [15:0] a16 = '0;
  logic [4:0]  c16;
`ifdef LZC_PIPE_NORM_EN
  logic [31:0] n32;
  logic [15:0] n16;
`endif

  always #5 clk = ~clk;

  lzc_pipe #(.WIDTH(24), .GROUP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .cnt_o(cnt_o), .zero_o(zero_o)
`ifdef LZC_PIPE_NORM_EN
    , .norm_o(norm_o)
`endif
  );

  lzc_pipe #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v32), .in_ready_o(ir32),
    .a_i(a32), .out_valid_o(ov32), .out_ready_i(1'b1),
    .cnt_o(c32), .zero_o(z32)
`ifdef LZC_PIPE_NORM_EN
    , .norm_o(n32)
`endif
  );

  lzc_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(v16), .in_ready_o(ir16),
    .a_i(a16), .out_valid_o(ov16), .out_ready_i(1'b1),
    .cnt_o(c16), .zero_o(z16)
`ifdef LZC_PIPE_NORM_EN
    , .norm_o(n16)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count zeros from the MSB bit by bit.
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          zero;
    logic [W-1:0]  norm;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] a);
    exp_t e;
    int   n;
    n = 0;
    while (n < W && !a[W-1-n]) n++;
    e.cnt  = CW'(n);
    e.zero = (a == '0);
    e.norm = a << n;
    return e;
  endfunction

  // Scoreboard: the input is pushed on a transfer, and the output is checked
  // on every valid cycle, so a stalled output must hold its value.
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_spurious: got out_valid_o=1 expected no result at %0t", $time);
        end else begin
          chk("sb_cnt", 64'(cnt_o), 64'(sb[0].cnt));
          chk("sb_zero", 64'(zero_o), 64'(sb[0].zero));
`ifdef LZC_PIPE_NORM_EN
          chk("sb_norm", 64'(norm_o), 64'(sb[0].norm));
`endif
          if (out_ready_i) void'(sb.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) sb.push_back(model(a_i));
    end
  end

  // Present one operand and wait, with a bound, until it is accepted.
  // Called away from the clock edges; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] a);
    logic acc;
    acc = 1'b0;
    in_valid_i = 1'b1;
    a_i = a;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
  endtask

  // Push one operand into an empty pipe with out_ready_i=1 and check the
  // exact 2-cycle latency against hand-computed values.
  task automatic run_one(input string name, input logic [W-1:0] a,
                         input int exp_cnt, input logic exp_zero, input logic [W-1:0] exp_norm);
    out_ready_i = 1'b1;
    send(a);
    @(negedge clk);
    chk({name, "_early"}, 64'(out_valid_o), 64'(0));
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid_o), 64'(1));
    chk({name, "_cnt"}, 64'(cnt_o), 64'(exp_cnt));
    chk({name, "_zero"}, 64'(zero_o), 64'(exp_zero));
`ifdef LZC_PIPE_NORM_EN
    chk({name, "_norm"}, 64'(norm_o), 64'(exp_norm));
`else
    if (exp_norm !== model(a).norm) chk({name, "_normref"}, 64'(model(a).norm), 64'(exp_norm));
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   acc;

    // The model itself, checked against hand-computed values.
    e = model(24'h800000); chk("model_800000", 64'(e.cnt), 64'(0));
    e = model(24'h000001); chk("model_000001", 64'(e.cnt), 64'(23));
    e = model(24'h000000); chk("model_zero_cnt", 64'(e.cnt), 64'(24));
    chk("model_zero_flag", 64'(e.zero), 64'(1));
    e = model(24'h00F000); chk("model_00F000_norm", 64'(e.norm), 64'(24'hF00000));

    // Reset state.
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'(0));
    chk("rst_cnt", 64'(cnt_o), 64'(0));
    chk("rst_zero", 64'(zero_o), 64'(0));
`ifdef LZC_PIPE_NORM_EN
    chk("rst_norm", 64'(norm_o), 64'(0));
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;

    // Single operands and slice boundaries.
    run_one("op_800000", 24'h800000, 0, 1'b0, 24'h800000);
    run_one("op_000001", 24'h000001, 23, 1'b0, 24'h800000);
    run_one("op_00F000", 24'h00F000, 8, 1'b0, 24'hF00000);
    run_one("op_zero", 24'h000000, 24, 1'b1, 24'h000000);
    run_one("op_008000", 24'h008000, 8, 1'b0, 24'h800000);
    run_one("op_000080", 24'h000080, 16, 1'b0, 24'h800000);
    run_one("op_010000", 24'h010000, 7, 1'b0, 24'h800000);

    // Backpressure: two operands are buffered, and the third is refused.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    a_i = 24'h400000;
    @(negedge clk); chk("bp_rdy_a", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;
    a_i = 24'h000100;
    @(negedge clk); chk("bp_rdy_b", 64'(in_ready_o), 64'(1));
    @(posedge clk); #1;
    a_i = 24'h000003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy_c", 64'(in_ready_o), 64'(0));
      chk("bp_hold_valid", 64'(out_valid_o), 64'(1));
      chk("bp_hold_cnt", 64'(cnt_o), 64'(1));
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 64'(in_ready_o), 64'(1));
    chk("bp_rel_cnt0", 64'(cnt_o), 64'(1));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    @(negedge clk); chk("bp_rel_cnt1", 64'(cnt_o), 64'(15));
    chk("bp_rel_v1", 64'(out_valid_o), 64'(1));
    @(posedge clk); #1;
    @(negedge clk); chk("bp_rel_cnt2", 64'(cnt_o), 64'(22));
    chk("bp_rel_v2", 64'(out_valid_o), 64'(1));
    @(posedge clk); #1;
    @(negedge clk); chk("bp_drained", 64'(out_valid_o), 64'(0));
    chk("bp_drain_hold", 64'(cnt_o), 64'(22));
    @(posedge clk); #1;

    // Full-rate streaming.
    out_ready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_valid_i = 1'b1;
      a_i = W'(i + 1);
      @(negedge clk);
      chk("stream_rdy", 64'(in_ready_o), 64'(1));
      if (i >= 2) chk("stream_valid", 64'(out_valid_o), 64'(1));
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while two operands are in flight.
    out_ready_i = 1'b0;
    send(24'h001234);
    send(24'h0000FF);
    @(negedge clk);
    chk("mid_pre_valid", 64'(out_valid_o), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid_clr", 64'(out_valid_o), 64'(0));
    chk("mid_cnt_clr", 64'(cnt_o), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_post_rdy", 64'(in_ready_o), 64'(1));
      chk("mid_post_stale", 64'(out_valid_o), 64'(0));
      @(posedge clk); #1;
    end

    // Parameter sweep on the 32/8 and 16/4 instances.
    v32 = 1'b1; a32 = 32'h0;
    v16 = 1'b1; a16 = 16'h0001;
    @(negedge clk);
    chk("sw_rdy32", 64'(ir32), 64'(1));
    chk("sw_rdy16", 64'(ir16), 64'(1));
    @(posedge clk); #1;
    v32 = 1'b1; a32 = 32'h0001_0000;
    v16 = 1'b1; a16 = 16'h0000;
    @(posedge clk); #1;
    v32 = 1'b0; v16 = 1'b0;
    @(negedge clk);
    chk("sw32_v", 64'(ov32), 64'(1));
    chk("sw32_zero_cnt", 64'(c32), 64'(32));
    chk("sw32_zero_flag", 64'(z32), 64'(1));
    chk("sw16_v", 64'(ov16), 64'(1));
    chk("sw16_one_cnt", 64'(c16), 64'(15));
    chk("sw16_one_flag", 64'(z16), 64'(0));
`ifdef LZC_PIPE_NORM_EN
    chk("sw32_zero_norm", 64'(n32), 64'(0));
    chk("sw16_one_norm", 64'(n16), 64'(16'h8000));
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw32_b_cnt", 64'(c32), 64'(15));
    chk("sw16_b_cnt", 64'(c16), 64'(16));
    chk("sw16_b_flag", 64'(z16), 64'(1));
    @(posedge clk); #1;

    // Random operands with random valid and backpressure.
    acc = 0;
    for (int it = 0; it < 40000 && acc < 10000; it++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      a_i         = W'($urandom) >> $urandom_range(0, W);
      out_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid_i && in_ready_o) acc++;
      @(posedge clk); #1;
    end
    chk("rand_accepted", 64'(acc), 64'(10000));
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int t = 0; t < 10 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("rand_drain", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
